// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner with frame-synchronous shadowing, leading-zero
// blanking and PWM brightness. Define SEG_SCAN_BLINK_EN to add per-digit blink.
module seg_scan_display #(
    parameter int DIGITS         = 8,
    parameter int CLK_DIV        = 50000,
    parameter int SEL_ACTIVE_LOW = 0,
    parameter int SEG_ACTIVE_LOW = 1
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES   = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   nums,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic [3:0]            bright,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [DIGITS-1:0]     blink,
`endif
    output logic [DIGITS-1:0]     sel,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic                  frame_tick
);

    localparam int CW     = $clog2(CLK_DIV);
    localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SLOT16 = CLK_DIV / 16;

    localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] nums_sh_q, nums_sh_d;
    logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_out_q, dp_out_d;
    logic                frame_tick_q, frame_tick_d;

    logic slot_end, last_digit, frame_end, shadow_ld;
    logic blink_mask;

    // Active-low font (0 = segment lit), order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_font(input logic [3:0] n);
        case (n)
            4'h0:    hex_font = 7'b1000000;
            4'h1:    hex_font = 7'b1111001;
            4'h2:    hex_font = 7'b0100100;
            4'h3:    hex_font = 7'b0110000;
            4'h4:    hex_font = 7'b0011001;
            4'h5:    hex_font = 7'b0010010;
            4'h6:    hex_font = 7'b0000010;
            4'h7:    hex_font = 7'b1111000;
            4'h8:    hex_font = 7'b0000000;
            4'h9:    hex_font = 7'b0010000;
            4'hA:    hex_font = 7'b0001000;
            4'hB:    hex_font = 7'b0000011;
            4'hC:    hex_font = 7'b1000110;
            4'hD:    hex_font = 7'b0100001;
            4'hE:    hex_font = 7'b0000110;
            default: hex_font = 7'b0001110;
        endcase
    endfunction

    assign slot_end   = (cnt_q == CW'(CLK_DIV - 1));
    assign last_digit = (idx_q == IW'(DIGITS - 1));
    assign frame_end  = en && slot_end && last_digit;
    assign shadow_ld  = !en || frame_end;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!en) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (slot_end) begin
            cnt_d = '0;
            idx_d = last_digit ? '0 : idx_q + IW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        nums_sh_d = shadow_ld ? nums : nums_sh_q;
        dp_sh_d   = shadow_ld ? dp   : dp_sh_q;
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [DIGITS-1:0] blink_sh_q, blink_sh_d;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
    logic              blink_off_q, blink_off_d;

    always_comb begin
        blink_sh_d  = shadow_ld ? blink : blink_sh_q;
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (frame_end) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
        blink_mask = blink_off_q && blink_sh_q[idx_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_sh_q  <= '0;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_sh_q  <= blink_sh_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end
`else
    assign blink_mask = 1'b0;
`endif

    // zero_above[i]: shadow nibbles i..DIGITS-1 are all zero.
    logic [DIGITS-1:0] zero_above;
    logic              zero_acc;

    always_comb begin
        zero_above = '0;
        zero_acc   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_acc      = zero_acc && (nums_sh_q[4*i +: 4] == 4'd0);
            zero_above[i] = zero_acc;
        end
    end

    logic [3:0]        nib;
    logic [6:0]        seg_lo;
    logic              dp_lo;
    logic              blanked;
    logic              pwm_on;
    logic [31:0]       on_len;
    logic [DIGITS-1:0] sel_raw;

    always_comb begin
        nib     = nums_sh_q[4*int'(idx_q) +: 4];
        blanked = blank_lz && (idx_q != '0) && zero_above[idx_q];
        seg_lo  = blanked ? 7'h7F : hex_font(nib);
        dp_lo   = ~dp_sh_q[idx_q];
        if (blink_mask) begin
            seg_lo = 7'h7F;
            dp_lo  = 1'b1;
        end

        on_len  = (32'(bright) + 32'd1) * 32'(SLOT16);
        pwm_on  = (32'(cnt_q) < on_len);
        sel_raw = '0;
        if (pwm_on) sel_raw[idx_q] = 1'b1;

        if (en) begin
            sel_d    = (SEL_ACTIVE_LOW != 0) ? ~sel_raw : sel_raw;
            seg_d    = (SEG_ACTIVE_LOW != 0) ? seg_lo : ~seg_lo;
            dp_out_d = (SEG_ACTIVE_LOW != 0) ? dp_lo : ~dp_lo;
        end else begin
            sel_d    = SEL_OFF;
            seg_d    = SEG_OFF;
            dp_out_d = DP_OFF;
        end
        frame_tick_d = frame_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            nums_sh_q    <= '0;
            dp_sh_q      <= '0;
            sel_q        <= SEL_OFF;
            seg_q        <= SEG_OFF;
            dp_out_q     <= DP_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            nums_sh_q    <= nums_sh_d;
            dp_sh_q      <= dp_sh_d;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
            dp_out_q     <= dp_out_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign sel        = sel_q;
    assign seg        = seg_q;
    assign dp_out     = dp_out_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display (DIGITS=4, CLK_DIV=16): a frame-position
// reference model checked every cycle, plus directed literal checks.
module tb_seg_scan_display;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 16;
    localparam int NFRAME  = DIGITS * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [15:0] nums = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  bright = 4'hF;
    logic [3:0]  sel;
    logic [6:0]  seg;
    logic        dp_out;
    logic        frame_tick;

    int checks = 0;
    int failures = 0;
    logic chk_on = 1'b0;

    seg_scan_display #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .SEL_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .nums(nums), .dp(dp),
        .blank_lz(blank_lz), .bright(bright),
        .sel(sel), .seg(seg), .dp_out(dp_out), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: position within the frame plus the frame-latched data.
    int          m_pos = 0;
    logic [15:0] m_nums = 16'h0;
    logic [3:0]  m_dp = 4'h0;
    logic [3:0]  e_sel = 4'h0;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;
    logic        e_ft = 1'b0;

    initial begin : model
        int digit, c;
        logic fend;
        logic [3:0] n;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pos = 0; m_nums = 16'h0; m_dp = 4'h0;
                e_sel = 4'h0; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
            end else begin
                digit = m_pos / CLK_DIV;
                c     = m_pos % CLK_DIV;
                fend  = en && (m_pos == NFRAME - 1);
                if (en) begin
                    n     = m_nums[4*digit +: 4];
                    e_sel = (c < (int'(bright) + 1) * CLK_DIV / 16) ? 4'(1 << digit) : 4'h0;
                    if (blank_lz && digit > 0 && (m_nums >> (4 * digit)) == 16'h0)
                        e_seg = 7'h7F;
                    else
                        e_seg = font[n];
                    e_dp = ~m_dp[digit];
                end else begin
                    e_sel = 4'h0; e_seg = 7'h7F; e_dp = 1'b1;
                end
                e_ft = fend;
                if (!en) begin
                    m_pos = 0; m_nums = nums; m_dp = dp;
                end else begin
                    if (fend) begin
                        m_nums = nums; m_dp = dp;
                    end
                    m_pos = (m_pos + 1) % NFRAME;
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("model_sel", 32'(sel), 32'(e_sel));
                chk("model_seg", 32'(seg), 32'(e_seg));
                chk("model_dp_out", 32'(dp_out), 32'(e_dp));
                chk("model_frame_tick", 32'(frame_tick), 32'(e_ft));
            end
        end
    end

    task automatic wait_sel(input logic [3:0] v, input string nm);
        int n = 0;
        @(negedge clk);
        while (sel !== v && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            failures++;
            checks++;
            $display("FAIL timeout_%s: sel=%0h expected %0h", nm, sel, v);
        end
    endtask

    task automatic wait_tick(input string nm);
        int n = 0;
        @(negedge clk);
        while (frame_tick !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            failures++;
            checks++;
            $display("FAIL timeout_%s: frame_tick never seen", nm);
        end
    endtask

    initial begin : stim
        int cnt;
        #1 rst_n = 1'b0;
        #2 chk_on = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_sel", 32'(sel), 32'h0);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_dp_out", 32'(dp_out), 32'h1);
        chk("reset_frame_tick", 32'(frame_tick), 32'h0);

        // Basic scan, nums=1234, full brightness
        nums = 16'h1234; bright = 4'hF;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("first_sel", 32'(sel), 32'h1);
        chk("digit0_seg_4", 32'(seg), 32'b0011001);
        wait_sel(4'b1000, "d3");
        chk("digit3_seg_1", 32'(seg), 32'b1111001);
        cnt = 0;
        for (int i = 0; i < NFRAME; i++) begin
            @(negedge clk);
            if (sel != 4'h0) cnt++;
        end
        chk("full_bright_on_cycles", 32'(cnt), 32'd64);
        wait_tick("tick_a");
        cnt = 0;
        @(negedge clk);
        while (frame_tick !== 1'b1 && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        chk("tick_period", 32'(cnt + 1), 32'd64);

        // Leading-zero blanking with decimal point
        en = 1'b0; nums = 16'h0050; blank_lz = 1'b1; dp = 4'b0010;
        @(negedge clk);
        en = 1'b1;
        wait_sel(4'b1000, "lz3");
        chk("lz_digit3_blank", 32'(seg), 32'h7F);
        wait_sel(4'b0100, "lz2");
        chk("lz_digit2_blank", 32'(seg), 32'h7F);
        wait_sel(4'b0010, "lz1");
        chk("lz_digit1_5", 32'(seg), 32'b0010010);
        chk("lz_digit1_dp", 32'(dp_out), 32'h0);
        wait_sel(4'b0001, "lz0");
        chk("lz_digit0_0", 32'(seg), 32'b1000000);

        // PWM at bright=3: 4 of 16 cycles per slot
        bright = 4'd3;
        repeat (2) @(negedge clk);
        cnt = 0;
        for (int i = 0; i < NFRAME; i++) begin
            @(negedge clk);
            if (sel != 4'h0) cnt++;
        end
        chk("pwm3_on_cycles", 32'(cnt), 32'd16);

        // Mid-frame data change is deferred to the next frame
        bright = 4'hF; blank_lz = 1'b0; dp = 4'h0;
        en = 1'b0; nums = 16'h1111;
        @(negedge clk);
        en = 1'b1;
        wait_sel(4'b0010, "mf1");
        nums = 16'h2222;
        wait_sel(4'b1000, "mf3");
        chk("midframe_old_digit3", 32'(seg), 32'b1111001);
        wait_tick("mf_tick");
        wait_sel(4'b0001, "mf_next0");
        chk("nextframe_digit0", 32'(seg), 32'b0100100);
        wait_sel(4'b1000, "mf_next3");
        chk("nextframe_digit3", 32'(seg), 32'b0100100);

        // en dropped mid-scan, then async reset mid-scan
        wait_sel(4'b0100, "en_drop");
        en = 1'b0;
        @(negedge clk);
        chk("en_off_sel", 32'(sel), 32'h0);
        chk("en_off_seg", 32'(seg), 32'h7F);
        chk("en_off_dp", 32'(dp_out), 32'h1);
        en = 1'b1;
        repeat (21) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_sel", 32'(sel), 32'h0);
        chk("async_rst_seg", 32'(seg), 32'h7F);
        chk("async_rst_dp", 32'(dp_out), 32'h1);
        chk("async_rst_tick", 32'(frame_tick), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_sel", 32'(sel), 32'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 4) begin
                nums = 16'($urandom);
                if ($urandom_range(0, 1) == 1) nums = nums >> (4 * $urandom_range(1, 4));
            end
            if ($urandom_range(0, 99) < 3) dp = 4'($urandom);
            if ($urandom_range(0, 99) < 2) blank_lz = 1'($urandom);
            if ($urandom_range(0, 99) < 2) bright = 4'($urandom_range(0, 15));
            if (en && $urandom_range(0, 499) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
